// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and defaults for the pipeline hazard controller
//
// Purpose:
//   Holds the constants and types used by pipe_hazard_ctrl and hazard_scoreboard:
//   - the default register-index width
//   - the PC source select encoding
//   - the redirect FSM state encoding
//   - the scoreboard depth
// Ports: none (package).

package cpu_pkg;

  // Default width of a register index (64 architectural registers).
  localparam int REG_W_DEF = 6;

  // Number of in-flight producer stages tracked: EX, MEM, WB.
  localparam int SB_DEPTH = 3;

  // Next-PC source select driven to the fetch stage.
  typedef enum logic [1:0] {
    PC_SRC_PLUS1  = 2'b00,  // sequential pc+1
    PC_SRC_PLUS_Y = 2'b01,  // pc-relative branch target
    PC_SRC_XRS    = 2'b10,  // register-indirect jump target
    PC_SRC_MEM    = 2'b11   // jump target loaded from memory
  } pc_src_e;

  // Redirect FSM: JMEM_WAIT spends one cycle waiting for the memory-loaded
  // jump target before steering the PC to it.
  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_JMEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker and RAW comparators
//
// Purpose:
//   Tracks the destination register of each instruction in EX, MEM and WB.
//   It flags a read-after-write hazard when the instruction in ID reads a
//   register that one of those instructions will still write.
//
// Ports:
//   clock       in   sole clock, all state updates on posedge
//   reset       in   synchronous active-high reset, clears every entry
//   id_valid    in   ID holds a real instruction
//   rs_id       in   ID source index A
//   rt_id       in   ID source index B
//   rd_id       in   ID destination index
//   useRs_id    in   ID actually reads rs
//   useRt_id    in   ID actually reads rt
//   load_valid  in   ID instruction is advancing into EX and writes back
//   raw_hazard  out  combinational RAW hazard indication for the ID instruction

module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic [REG_W-1:0] rd_id,
  input  logic             useRs_id,
  input  logic             useRt_id,
  input  logic             load_valid,
  output logic             raw_hazard
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  sb_entry_t sb [SB_DEPTH];

  // The scoreboard shifts every cycle, stalled or not. A stall or redirect
  // loads a bubble into EX, so older producers keep draining toward WB.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb[i] <= '0;
      end
    end else begin
      sb[0].valid <= load_valid;
      sb[0].rd    <= rd_id;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  // Register 0 is hard-wired, so a pending write to it never blocks a reader.
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb[i].valid && (sb[i].rd != '0)) begin
        if (useRs_id && (rs_id == sb[i].rd)) raw_hazard = 1'b1;
        if (useRt_id && (rt_id == sb[i].rd)) raw_hazard = 1'b1;
      end
    end
    raw_hazard = raw_hazard & id_valid;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/redirect controller with perf counters
//
// Purpose:
//   Decides each cycle whether the front end advances, stalls on a RAW hazard,
//   or is redirected by a taken branch, a jump, or a memory-indirect jump.
//   Control outputs are combinational from the current state, the scoreboard
//   and the current inputs. It also counts stall cycles and redirect-flush
//   cycles in saturating counters.
//
// Ports:
//   clock          in   sole clock
//   reset          in   synchronous active-high reset
//   id_valid       in   ID holds a real instruction
//   rs_id          in   ID source index A
//   rt_id          in   ID source index B
//   rd_id          in   ID destination index
//   useRs_id       in   ID reads rs
//   useRt_id       in   ID reads rt
//   regWrt_id      in   ID writes rd
//   memRead_id     in   ID is a load
//   branchZero_ex  in   EX branch-if-zero
//   branchNeg_ex   in   EX branch-if-negative
//   jump_ex        in   EX register jump
//   jumpMem_ex     in   EX memory-indirect jump
//   zero_ex        in   EX ALU zero flag
//   neg_ex         in   EX ALU negative flag
//   pc_write       out  PC advance enable
//   ifid_write     out  IF/ID advance enable
//   ifid_flush     out  bubble IF/ID
//   idex_flush     out  bubble ID/EX
//   pc_src         out  next-PC select (pc_src_e)
//   stall_cnt      out  saturating RAW-stall cycle count
//   flush_cnt      out  saturating redirect-flush cycle count

module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic [REG_W-1:0] rd_id,
  input  logic             useRs_id,
  input  logic             useRt_id,
  input  logic             regWrt_id,
  input  logic             memRead_id,
  input  logic             branchZero_ex,
  input  logic             branchNeg_ex,
  input  logic             jump_ex,
  input  logic             jumpMem_ex,
  input  logic             zero_ex,
  input  logic             neg_ex,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       pc_src,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e state;

  logic taken;
  logic redirect;
  logic raw_hazard;
  logic stall;
  logic sb_load;

  // Load-ness does not matter here: every producer is held off until it
  // leaves WB, so loads and ALU ops look the same.
  logic unused_mem_read;
  assign unused_mem_read = memRead_id;

  assign taken = (branchZero_ex & zero_ex) | (branchNeg_ex & neg_ex) | jump_ex;

  // In JMEM_WAIT the EX-stage inputs belong to squashed instructions. The
  // wait state alone is therefore a redirect and decides the outputs.
  assign redirect = (state == ST_JMEM_WAIT) | jumpMem_ex | taken;

  // A redirect squashes the ID instruction anyway, so its hazard is moot.
  assign stall = raw_hazard & ~redirect;

  // Only an instruction that really advances into EX occupies a slot.
  assign sb_load = id_valid & regWrt_id & ~stall & ~redirect;

  hazard_scoreboard #(
    .REG_W (REG_W)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .id_valid   (id_valid),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .rd_id      (rd_id),
    .useRs_id   (useRs_id),
    .useRt_id   (useRt_id),
    .load_valid (sb_load),
    .raw_hazard (raw_hazard)
  );

  // Redirect FSM. Reset abandons a pending memory jump.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:       if (jumpMem_ex) state <= ST_JMEM_WAIT;
        ST_JMEM_WAIT: state <= ST_RUN;
        default:      state <= ST_RUN;
      endcase
    end
  end

  // Output decode, highest priority first: reset, memory-jump wait,
  // memory-jump issue, taken branch/jump, RAW stall, normal advance.
  // jumpMem_ex outranks taken because the memory target supersedes any
  // concurrent branch decision.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_src     = PC_SRC_PLUS1;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == ST_JMEM_WAIT) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pc_src     = PC_SRC_MEM;
    end else if (jumpMem_ex) begin
      // Hold the PC for one cycle while the target is fetched from memory.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pc_src     = jump_ex ? PC_SRC_XRS : PC_SRC_PLUS_Y;
    end else if (raw_hazard) begin
      // Freeze PC and IF/ID; inject a bubble into EX.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Saturating performance counters. Stall bubbles are counted separately
  // from redirect flushes even though both assert idex_flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard testbench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 6;

  typedef struct packed {
    logic             reset;
    logic             id_valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             use_rs;
    logic             use_rt;
    logic             regwrt;
    logic             memread;
    logic             bz;
    logic             bn;
    logic             j;
    logic             jm;
    logic             zero;
    logic             neg;
  } stim_t;

  typedef struct {
    logic [5:0] ctrl;   // {pc_write, ifid_write, ifid_flush, idex_flush, pc_src}
    int         stall;
    int         flush;
  } exp_t;

  typedef struct {
    logic [REG_W-1:0] rd;
    int               left;
  } pend_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic [REG_W-1:0] rs_id = '0, rt_id = '0, rd_id = '0;
  logic useRs_id = 1'b0, useRt_id = 1'b0, regWrt_id = 1'b0, memRead_id = 1'b0;
  logic branchZero_ex = 1'b0, branchNeg_ex = 1'b0, jump_ex = 1'b0, jumpMem_ex = 1'b0;
  logic zero_ex = 1'b0, neg_ex = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]  pc_src;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush;
  logic [1:0]  s_pc_src;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .useRs_id(useRs_id), .useRt_id(useRt_id), .regWrt_id(regWrt_id), .memRead_id(memRead_id),
    .branchZero_ex(branchZero_ex), .branchNeg_ex(branchNeg_ex), .jump_ex(jump_ex),
    .jumpMem_ex(jumpMem_ex), .zero_ex(zero_ex), .neg_ex(neg_ex),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pc_src(pc_src), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .useRs_id(useRs_id), .useRt_id(useRt_id), .regWrt_id(regWrt_id), .memRead_id(memRead_id),
    .branchZero_ex(branchZero_ex), .branchNeg_ex(branchNeg_ex), .jump_ex(jump_ex),
    .jumpMem_ex(jumpMem_ex), .zero_ex(zero_ex), .neg_ex(neg_ex),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .pc_src(s_pc_src), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  exp_t  exp_q[$];
  exp_t  mon_e;

  // Reference model state: writes still in flight, memory-jump pending,
  // unbounded event counts (saturation applied when compared).
  pend_t pend_q[$];
  bit    m_jmem = 1'b0;
  int    m_stall = 0;
  int    m_flush = 0;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit    hz, tk, redir, stalled;
    pend_t nq[$];
    e.stall = m_stall;
    e.flush = m_flush;
    if (s.reset) begin
      e.ctrl = 6'b00_11_00;
      pend_q.delete();
      m_jmem  = 1'b0;
      m_stall = 0;
      m_flush = 0;
      return;
    end
    hz = 1'b0;
    if (s.id_valid) begin
      foreach (pend_q[i]) begin
        if (pend_q[i].rd != 0 &&
            ((s.use_rs && s.rs == pend_q[i].rd) || (s.use_rt && s.rt == pend_q[i].rd)))
          hz = 1'b1;
      end
    end
    tk = (s.bz && s.zero) || (s.bn && s.neg) || s.j;
    redir = 1'b1;
    if (m_jmem) begin
      e.ctrl = 6'b11_11_11;
      m_jmem = 1'b0;
    end else if (s.jm) begin
      e.ctrl = 6'b00_11_00;
      m_jmem = 1'b1;
    end else if (tk) begin
      e.ctrl = s.j ? 6'b11_11_10 : 6'b11_11_01;
    end else begin
      redir = 1'b0;
      e.ctrl = hz ? 6'b00_01_00 : 6'b11_00_00;
    end
    stalled = !redir && hz;
    if (stalled) m_stall++;
    if (redir) m_flush++;
    foreach (pend_q[i]) begin
      if (pend_q[i].left > 1) nq.push_back('{pend_q[i].rd, pend_q[i].left - 1});
    end
    pend_q = nq;
    // A writer that advances stays visible while in EX, MEM and WB.
    if (s.id_valid && s.regwrt && !redir && !stalled) pend_q.push_back('{s.rd, 3});
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clock);
    #1;
    reset = s.reset; id_valid = s.id_valid;
    rs_id = s.rs; rt_id = s.rt; rd_id = s.rd;
    useRs_id = s.use_rs; useRt_id = s.use_rt; regWrt_id = s.regwrt; memRead_id = s.memread;
    branchZero_ex = s.bz; branchNeg_ex = s.bn; jump_ex = s.j; jumpMem_ex = s.jm;
    zero_ex = s.zero; neg_ex = s.neg;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t r;
    r = '0;
    return r;
  endfunction

  function automatic stim_t rst();
    stim_t r;
    r = '0;
    r.reset = 1'b1;
    return r;
  endfunction

  function automatic stim_t producer(input int rd);
    stim_t r;
    r = '0;
    r.id_valid = 1'b1; r.regwrt = 1'b1; r.rd = REG_W'(rd);
    return r;
  endfunction

  function automatic stim_t consumer(input int rs);
    stim_t r;
    r = '0;
    r.id_valid = 1'b1; r.use_rs = 1'b1; r.rs = REG_W'(rs); r.rd = REG_W'(9);
    return r;
  endfunction

  function automatic stim_t rand_stim();
    stim_t r;
    r = '0;
    r.reset    = ($urandom_range(99) == 0);
    r.id_valid = ($urandom_range(9) < 8);
    r.rs       = REG_W'($urandom_range(7));
    r.rt       = REG_W'($urandom_range(7));
    r.rd       = REG_W'($urandom_range(7));
    r.use_rs   = ($urandom_range(9) < 6);
    r.use_rt   = ($urandom_range(9) < 4);
    r.regwrt   = ($urandom_range(9) < 6);
    r.memread  = ($urandom_range(3) == 0);
    r.bz       = ($urandom_range(9) == 0);
    r.bn       = ($urandom_range(9) == 0);
    r.j        = ($urandom_range(19) == 0);
    r.jm       = ($urandom_range(19) == 0);
    r.zero     = $urandom_range(1) != 0;
    r.neg      = $urandom_range(1) != 0;
    return r;
  endfunction

  // Monitor: every cycle the DUT presents a response, compare it to the
  // oldest expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ctrl", 32'({pc_write, ifid_write, ifid_flush, idex_flush, pc_src}), 32'(mon_e.ctrl));
      check("ctrl_w4", 32'({s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_pc_src}), 32'(mon_e.ctrl));
      check("stall_cnt", 32'(stall_cnt), 32'(sat(mon_e.stall, 16)));
      check("flush_cnt", 32'(flush_cnt), 32'(sat(mon_e.flush, 16)));
      check("stall_cnt_w4", 32'(s_stall_cnt), 32'(sat(mon_e.stall, 4)));
      check("flush_cnt_w4", 32'(s_flush_cnt), 32'(sat(mon_e.flush, 4)));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;

    drive(rst()); drive(rst());

    // RAW on r5: three stall cycles then advance.
    drive(rst());
    drive(producer(5));
    repeat (4) drive(consumer(5));
    drive(idle());
    @(negedge clock);
    check("raw_r5_stall_cnt", 32'(stall_cnt), 32'd3);

    // Branch-if-zero taken, then not taken.
    drive(rst());
    s = idle(); s.bz = 1'b1; s.zero = 1'b1; drive(s);
    s.zero = 1'b0; drive(s);
    drive(idle());
    @(negedge clock);
    check("bz_flush_cnt", 32'(flush_cnt), 32'd1);

    // Memory-indirect jump; jumpMem_ex held high in the wait cycle is ignored.
    drive(rst());
    s = idle(); s.jm = 1'b1; drive(s); drive(s);
    drive(idle());
    @(negedge clock);
    check("jmem_flush_cnt", 32'(flush_cnt), 32'd2);

    // RAW on r7 coinciding with a register jump: redirect wins.
    drive(rst());
    drive(producer(7));
    s = consumer(7); s.j = 1'b1; drive(s);
    drive(idle());
    @(negedge clock);
    check("r7_jump_stall_cnt", 32'(stall_cnt), 32'd0);
    check("r7_jump_flush_cnt", 32'(flush_cnt), 32'd1);

    // Reset during JMEM_WAIT, then an r0 producer/consumer pair.
    drive(rst());
    s = idle(); s.jm = 1'b1; drive(s);
    drive(rst());
    drive(idle());
    @(negedge clock);
    check("jmem_reset_flush_cnt", 32'(flush_cnt), 32'd0);
    drive(producer(0));
    s = consumer(0); s.use_rt = 1'b1; drive(s);
    drive(idle());
    @(negedge clock);
    check("r0_no_stall", 32'(stall_cnt), 32'd0);

    // 21 stall cycles: the 4-bit counters saturate at 15.
    drive(rst());
    repeat (7) begin
      drive(producer(3));
      repeat (4) drive(consumer(3));
    end
    drive(idle());
    @(negedge clock);
    check("sat_w4_stall_cnt", 32'(s_stall_cnt), 32'd15);
    check("sat_w16_stall_cnt", 32'(stall_cnt), 32'd21);

    // Randomized traffic against the reference model.
    drive(rst());
    repeat (2000) drive(rand_stim());

    @(negedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
